// File: rtl/regfile_sb.sv
// regfile_sb: parametrised two-read / one-write register file with
// same-cycle write forwarding and a per-register pending-write scoreboard.
// Optional feature macro: REGF_ZERO_REG_EN (register 0 hardwired to zero,
// never forwarded, never marked busy).
module regfile_sb #(
   parameter  int REGF_WIDTH = 16,
   parameter  int REGF_DEPTH = 4,
   localparam int ADDR_W     = $clog2(REGF_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     rd,
   input  logic [REGF_WIDTH-1:0] alu_input,
   input  logic [ADDR_W-1:0]     rs1,
   input  logic [ADDR_W-1:0]     rs2,
   output logic [REGF_WIDTH-1:0] reg_out_op1,
   output logic [REGF_WIDTH-1:0] reg_out_op2,
   input  logic                  alloc_en,
   input  logic [ADDR_W-1:0]     alloc_rd,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic [REGF_DEPTH-1:0] busy_vec
);

`ifdef REGF_ZERO_REG_EN
   localparam int FIRST_REG = 1;
`else
   localparam int FIRST_REG = 0;
`endif

   logic [REGF_WIDTH-1:0] r_regs [REGF_DEPTH];
   logic [REGF_DEPTH-1:0] r_busy;

   logic [REGF_WIDTH-1:0] w_rdData1;
   logic [REGF_WIDTH-1:0] w_rdData2;
   logic                  w_hit1;
   logic                  w_hit2;
   logic                  w_busyRaw1;
   logic                  w_busyRaw2;
   logic                  w_wrMatch1;
   logic                  w_wrMatch2;

   // Register storage: cleared by reset, written at rd when we is high.
   // Addresses with no matching register (or register 0 when hardwired)
   // are simply never written, so they keep their reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REGF_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = FIRST_REG; i < REGF_DEPTH; i++) begin
            if (we && (rd == ADDR_W'(i))) begin
               r_regs[i] <= alu_input;
            end
         end
      end
   end

   // Scoreboard: alloc marks a register pending, write-back clears it; a new
   // producer on the same register supersedes the one completing, so set wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         for (int i = FIRST_REG; i < REGF_DEPTH; i++) begin
            if (alloc_en && (alloc_rd == ADDR_W'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (we && (rd == ADDR_W'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   // Read muxes built as an explicit match so out-of-range addresses give 0
   // and never index past the array; the hit flag also gates forwarding.
   always_comb begin
      w_rdData1  = '0;
      w_rdData2  = '0;
      w_hit1     = 1'b0;
      w_hit2     = 1'b0;
      w_busyRaw1 = 1'b0;
      w_busyRaw2 = 1'b0;
      for (int i = FIRST_REG; i < REGF_DEPTH; i++) begin
         if (rs1 == ADDR_W'(i)) begin
            w_rdData1  = r_regs[i];
            w_hit1     = 1'b1;
            w_busyRaw1 = r_busy[i];
         end
         if (rs2 == ADDR_W'(i)) begin
            w_rdData2  = r_regs[i];
            w_hit2     = 1'b1;
            w_busyRaw2 = r_busy[i];
         end
      end
   end

   // Forwarding and ready logic: data being written this cycle is visible
   // immediately and counts as ready; forwarding is held off during reset.
   always_comb begin
      w_wrMatch1  = we && (rd == rs1);
      w_wrMatch2  = we && (rd == rs2);
      reg_out_op1 = (rst && w_hit1 && w_wrMatch1) ? alu_input : w_rdData1;
      reg_out_op2 = (rst && w_hit2 && w_wrMatch2) ? alu_input : w_rdData2;
      rs1_busy    = w_busyRaw1 && !w_wrMatch1;
      rs2_busy    = w_busyRaw2 && !w_wrMatch2;
      busy_vec    = r_busy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb. A default
// (depth 4) instance and a depth-3 instance share the same stimulus.
// Expectations for register 0 follow REGF_ZERO_REG_EN when it is defined.
`timescale 1ns/1ps
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  rd;
   logic [15:0] alu_input;
   logic [1:0]  rs1;
   logic [1:0]  rs2;
   logic        alloc_en;
   logic [1:0]  alloc_rd;

   logic [15:0] opA1, opA2;
   logic        busyA1, busyA2;
   logic [3:0]  busyVecA;

   logic [15:0] opB1, opB2;
   logic        busyB1, busyB2;
   logic [2:0]  busyVecB;

   int checks = 0;
   int errors = 0;

`ifdef REGF_ZERO_REG_EN
   localparam logic [15:0] ZERO_WR_EXP  = 16'h0000;
   localparam logic        ZERO_BSY_EXP = 1'b0;
`else
   localparam logic [15:0] ZERO_WR_EXP  = 16'hFFFF;
   localparam logic        ZERO_BSY_EXP = 1'b1;
`endif

   regfile_sb #(.REGF_WIDTH(16), .REGF_DEPTH(4)) dutA (
      .clk(clk), .rst(rst), .we(we), .rd(rd), .alu_input(alu_input),
      .rs1(rs1), .rs2(rs2), .reg_out_op1(opA1), .reg_out_op2(opA2),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .rs1_busy(busyA1), .rs2_busy(busyA2), .busy_vec(busyVecA)
   );

   regfile_sb #(.REGF_WIDTH(16), .REGF_DEPTH(3)) dutB (
      .clk(clk), .rst(rst), .we(we), .rd(rd), .alu_input(alu_input),
      .rs1(rs1), .rs2(rs2), .reg_out_op1(opB1), .reg_out_op2(opB2),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .rs1_busy(busyB1), .rs2_busy(busyB2), .busy_vec(busyVecB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; alloc_en = 1'b0;
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
      we = 1'b1; rd = a; alu_input = d; alloc_en = 1'b0;
      tick();
      we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; idle(); rd = 2'd0; alu_input = 16'h0; rs1 = 2'd0; rs2 = 2'd0; alloc_rd = 2'd0;
      tick(); tick();
      rst = 1'b1;
      rs1 = 2'd1; rs2 = 2'd3;
      #1;
      checks++;
      if (opA1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_op1: got %h expected 0000", opA1); end
      checks++;
      if (opA2 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_op2: got %h expected 0000", opA2); end
      checks++;
      if (busyVecA !== 4'b0000) begin errors++; $display("[TB] FAIL reset_busy_vec: got %b expected 0000", busyVecA); end
      checks++;
      if (busyVecB !== 3'b000) begin errors++; $display("[TB] FAIL reset_busy_vec_b: got %b expected 000", busyVecB); end
   endtask

   task automatic test_write();
      we = 1'b1; rd = 2'd2; alu_input = 16'hBEEF;
      tick();
      we = 1'b0; alu_input = 16'h1234; rs1 = 2'd2;
      #1;
      checks++;
      if (opA1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL we_gating_no_fwd: got %h expected beef", opA1); end
      tick();
      checks++;
      if (opA1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_readback: got %h expected beef", opA1); end
      checks++;
      if (opB1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_readback_b: got %h expected beef", opB1); end
   endtask

   task automatic test_forward();
      writeReg(2'd1, 16'h0005);
      rs1 = 2'd1; rs2 = 2'd1;
      #1;
      checks++;
      if (opA1 !== 16'h0005) begin errors++; $display("[TB] FAIL fwd_pre_value: got %h expected 0005", opA1); end
      we = 1'b1; rd = 2'd1; alu_input = 16'h00AA;
      #1;
      checks++;
      if (opA1 !== 16'h00AA) begin errors++; $display("[TB] FAIL fwd_op1: got %h expected 00aa", opA1); end
      checks++;
      if (opA2 !== 16'h00AA) begin errors++; $display("[TB] FAIL fwd_op2: got %h expected 00aa", opA2); end
      tick();
      we = 1'b0; alu_input = 16'h7777;
      #1;
      checks++;
      if ({opA1, opA2} !== {16'h00AA, 16'h00AA}) begin errors++; $display("[TB] FAIL fwd_after_edge: got %h/%h expected 00aa/00aa", opA1, opA2); end
   endtask

   task automatic test_scoreboard();
      alloc_en = 1'b1; alloc_rd = 2'd3;
      tick();
      alloc_en = 1'b0; rs1 = 2'd3; rs2 = 2'd3;
      #1;
      checks++;
      if (busyVecA !== 4'b1000) begin errors++; $display("[TB] FAIL sb_alloc_vec: got %b expected 1000", busyVecA); end
      checks++;
      if (busyA2 !== 1'b1) begin errors++; $display("[TB] FAIL sb_rs2_busy: got %b expected 1", busyA2); end
      we = 1'b1; rd = 2'd3; alu_input = 16'h3333;
      #1;
      checks++;
      if (busyA1 !== 1'b0) begin errors++; $display("[TB] FAIL sb_fwd_ready: got %b expected 0", busyA1); end
      checks++;
      if (busyVecA !== 4'b1000) begin errors++; $display("[TB] FAIL sb_vec_no_fwd: got %b expected 1000", busyVecA); end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (busyVecA !== 4'b0000) begin errors++; $display("[TB] FAIL sb_clear: got %b expected 0000", busyVecA); end
      we = 1'b1; rd = 2'd3; alu_input = 16'h3334; alloc_en = 1'b1; alloc_rd = 2'd3;
      tick();
      idle();
      #1;
      checks++;
      if (busyVecA !== 4'b1000) begin errors++; $display("[TB] FAIL sb_set_wins: got %b expected 1000", busyVecA); end
      we = 1'b1; rd = 2'd3; alloc_en = 1'b1; alloc_rd = 2'd1;
      tick();
      idle();
      #1;
      checks++;
      if (busyVecA !== 4'b0010) begin errors++; $display("[TB] FAIL sb_set_clear_diff: got %b expected 0010", busyVecA); end
      writeReg(2'd1, 16'h0001);
      #1;
      checks++;
      if (busyVecA !== 4'b0000) begin errors++; $display("[TB] FAIL sb_cleanup: got %b expected 0000", busyVecA); end
   endtask

   task automatic test_async_reset();
      writeReg(2'd0, 16'h1111);
      writeReg(2'd1, 16'h2222);
      writeReg(2'd2, 16'h3333);
      writeReg(2'd3, 16'h4444);
      alloc_en = 1'b1; alloc_rd = 2'd1;
      tick();
      alloc_rd = 2'd2;
      tick();
      alloc_en = 1'b0;
      rs1 = 2'd1; rs2 = 2'd3;
      #1;
      checks++;
      if ({opA1, opA2} !== {16'h2222, 16'h4444}) begin errors++; $display("[TB] FAIL ar_preload: got %h/%h expected 2222/4444", opA1, opA2); end
      checks++;
      if (busyVecA !== 4'b0110) begin errors++; $display("[TB] FAIL ar_pre_busy: got %b expected 0110", busyVecA); end
      #1;
      rst = 1'b0;
      we = 1'b1; rd = 2'd1; alu_input = 16'hABCD;
      #1;
      checks++;
      if ({opA1, opA2} !== 32'h0) begin errors++; $display("[TB] FAIL ar_outputs_zero: got %h/%h expected 0000/0000", opA1, opA2); end
      checks++;
      if (busyVecA !== 4'b0000) begin errors++; $display("[TB] FAIL ar_busy_zero: got %b expected 0000", busyVecA); end
      tick();
      idle();
      rst = 1'b1;
      #1;
      checks++;
      if (opA1 !== 16'h0000) begin errors++; $display("[TB] FAIL ar_no_write_in_reset: got %h expected 0000", opA1); end
   endtask

   task automatic test_zero_reg();
      we = 1'b1; rd = 2'd0; alu_input = 16'hFFFF; alloc_en = 1'b1; alloc_rd = 2'd0; rs1 = 2'd0;
      #1;
      checks++;
      if (opA1 !== ZERO_WR_EXP) begin errors++; $display("[TB] FAIL zero_fwd: got %h expected %h", opA1, ZERO_WR_EXP); end
      tick();
      idle();
      #1;
      checks++;
      if (opA1 !== ZERO_WR_EXP) begin errors++; $display("[TB] FAIL zero_read: got %h expected %h", opA1, ZERO_WR_EXP); end
      checks++;
      if (busyVecA[0] !== ZERO_BSY_EXP) begin errors++; $display("[TB] FAIL zero_busy: got %b expected %b", busyVecA[0], ZERO_BSY_EXP); end
      writeReg(2'd0, 16'h0000);
   endtask

   task automatic test_out_of_range();
      writeReg(2'd1, 16'h0101);
      writeReg(2'd2, 16'h0202);
      we = 1'b1; rd = 2'd3; alu_input = 16'hDEAD; alloc_en = 1'b1; alloc_rd = 2'd3; rs1 = 2'd3;
      #1;
      checks++;
      if (opB1 !== 16'h0000) begin errors++; $display("[TB] FAIL oor_no_fwd: got %h expected 0000", opB1); end
      tick();
      idle();
      #1;
      checks++;
      if (opB1 !== 16'h0000) begin errors++; $display("[TB] FAIL oor_read: got %h expected 0000", opB1); end
      checks++;
      if (busyB1 !== 1'b0) begin errors++; $display("[TB] FAIL oor_busy: got %b expected 0", busyB1); end
      checks++;
      if (busyVecB !== 3'b000) begin errors++; $display("[TB] FAIL oor_busy_vec: got %b expected 000", busyVecB); end
      checks++;
      if (opA1 !== 16'hDEAD) begin errors++; $display("[TB] FAIL oor_depth4_write: got %h expected dead", opA1); end
      rs1 = 2'd1; rs2 = 2'd2;
      #1;
      checks++;
      if ({opB1, opB2} !== {16'h0101, 16'h0202}) begin errors++; $display("[TB] FAIL oor_regs_unchanged: got %h/%h expected 0101/0202", opB1, opB2); end
      rs1 = 2'd0; rs2 = 2'd0;
      #1;
      checks++;
      if ((opB1 !== 16'h0000) || (opB1 !== opB2) || (busyB1 !== busyB2)) begin errors++; $display("[TB] FAIL oor_reg0_dual_read: got %h/%h expected 0000/0000", opB1, opB2); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_forward();
      test_scoreboard();
      test_async_reset();
      test_zero_reg();
      test_out_of_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
